// File: rtl/care_scheduler.sv
// Care-action scheduler: decay tick and stat selector generation, button/auto arbitration, per-action cooldown.
// Optional feature macro: CARE_SCHED_AGING_EN (auto requests win after 7 button grants while waiting).
module care_scheduler #(
   parameter int TICK_DIV = 10_000_000,
   parameter int COOLDOWN = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [5:0] req_btn,
   input  logic [5:0] req_auto,
   output logic [5:0] act_pulse,
   output logic       act_src,
   output logic       decay_tick,
   output logic [4:0] decay_sel,
   output logic [5:0] cooling
);
   localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
   localparam logic [3:0] CD_LOAD = 4'(COOLDOWN);

   typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q, tick_d;
   logic [4:0]    sel_q, sel_d;
   logic [4:0]    lfsr_q, lfsr_d;
   logic [5:0]    pend_btn_q, pend_btn_d;
   logic [5:0]    pend_auto_q, pend_auto_d;
   logic [2:0]    rr_q, rr_d;
   logic [2:0]    win_q, win_d;
   logic          src_q, src_d;
   logic [3:0]    cd_q [6];
   logic [3:0]    cd_d [6];

   logic [5:0]    elig_btn, elig_auto, cand, cand_rot, win_oh, clr_btn, clr_auto;
   logic [11:0]   cand_dbl;
   logic [2:0]    rot_pos, pick;
   logic [3:0]    pick_sum;
   logic          use_auto, commit, wrap, decide;

   assign wrap   = enable && (cnt_q == TICK_LAST);
   assign cnt_d  = !enable ? cnt_q : ((cnt_q == TICK_LAST) ? '0 : cnt_q + 1'b1);
   assign tick_d = wrap;
   assign lfsr_d = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
   assign sel_d  = wrap ? (lfsr_q % 5'd6) : sel_q;

   assign commit = (state_q == GRANT);
   assign win_oh = 6'b000001 << win_q;

   for (genvar gi = 0; gi < 6; gi++) begin : g_act
      assign elig_btn[gi]  = pend_btn_q[gi] && (cd_q[gi] == 4'd0);
      assign elig_auto[gi] = pend_auto_q[gi] && (cd_q[gi] == 4'd0);
      assign cooling[gi]   = (cd_q[gi] != 4'd0);
      // A grant never shares a cycle with decay_tick, so load and decrement cannot collide.
      assign cd_d[gi] = (commit && (win_q == 3'(gi))) ? CD_LOAD :
                        (tick_q && (cd_q[gi] != 4'd0)) ? cd_q[gi] - 4'd1 : cd_q[gi];
   end

`ifdef CARE_SCHED_AGING_EN
   logic [2:0] age_q, age_d;
   assign use_auto = (elig_btn == '0) || ((age_q == 3'd7) && (elig_auto != '0));
   always_comb begin
      age_d = age_q;
      if (decide) begin
         if (use_auto)
            age_d = '0;
         else if ((elig_auto != '0) && (age_q != 3'd7))
            age_d = age_q + 3'd1;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) age_q <= '0;
      else       age_q <= age_d;
   end
`else
   assign use_auto = (elig_btn == '0);
`endif

   // Round-robin search: rotate candidates so rr_q lands on bit 0, take the lowest set bit.
   assign cand     = use_auto ? elig_auto : elig_btn;
   assign cand_dbl = {cand, cand};
   assign cand_rot = cand_dbl[rr_q +: 6];
   always_comb begin
      rot_pos = '0;
      for (int k = 5; k >= 0; k--)
         if (cand_rot[k]) rot_pos = 3'(k);
   end
   assign pick_sum = {1'b0, rr_q} + {1'b0, rot_pos};
   assign pick     = (pick_sum >= 4'd6) ? 3'(pick_sum - 4'd6) : pick_sum[2:0];

   // GAP also evaluates, giving back-to-back actions one per two cycles.
   assign decide = (state_q != GRANT) && enable && (cnt_q != TICK_LAST) && (cand != '0);

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      src_d   = src_q;
      case (state_q)
         IDLE, GAP: begin
            if (decide) begin
               state_d = GRANT;
               win_d   = pick;
               src_d   = use_auto;
            end else begin
               state_d = IDLE;
            end
         end
         GRANT:   state_d = GAP;
         default: state_d = IDLE;
      endcase
   end

   assign clr_btn     = (commit && !src_q) ? win_oh : '0;
   assign clr_auto    = (commit &&  src_q) ? win_oh : '0;
   assign pend_btn_d  = enable ? ((pend_btn_q  & ~clr_btn)  | req_btn)  : '0;
   assign pend_auto_d = enable ? ((pend_auto_q & ~clr_auto) | req_auto) : '0;
   assign rr_d        = commit ? ((win_q == 3'd5) ? 3'd0 : win_q + 3'd1) : rr_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         tick_q      <= 1'b0;
         sel_q       <= '0;
         lfsr_q      <= 5'b00001;
         pend_btn_q  <= '0;
         pend_auto_q <= '0;
         rr_q        <= '0;
         win_q       <= '0;
         src_q       <= 1'b0;
         for (int i = 0; i < 6; i++) cd_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tick_q      <= tick_d;
         sel_q       <= sel_d;
         lfsr_q      <= lfsr_d;
         pend_btn_q  <= pend_btn_d;
         pend_auto_q <= pend_auto_d;
         rr_q        <= rr_d;
         win_q       <= win_d;
         src_q       <= src_d;
         cd_q        <= cd_d;
      end
   end

   // Reset aborts an in-flight grant within its own cycle.
   assign act_pulse  = (commit && !reset) ? win_oh : '0;
   assign act_src    = src_q;
   assign decay_tick = tick_q;
   assign decay_sel  = sel_q;

endmodule

// File: tb/tb_care_scheduler.sv
// Bench for care_scheduler: per-cycle behavioural model comparison plus directed literal checks.
module tb_care_scheduler;
   localparam int TD  = 8;
   localparam int CDN = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [5:0] req_btn = '0;
   logic [5:0] req_auto = '0;
   logic [5:0] act_pulse;
   logic       act_src;
   logic       decay_tick;
   logic [4:0] decay_sel;
   logic [5:0] cooling;

   care_scheduler #(.TICK_DIV(TD), .COOLDOWN(CDN)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .req_btn(req_btn), .req_auto(req_auto),
      .act_pulse(act_pulse), .act_src(act_src),
      .decay_tick(decay_tick), .decay_sel(decay_sel), .cooling(cooling)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int n_pulse = 0, n_auto = 0, n_tick = 0;
   bit started = 0;

   // Model state: phase 0 = waiting, 1 = pulse cycle, 2 = cycle after a pulse.
   int       m_cyc, m_cnt, m_sel, m_lfsr, m_rr, m_phase, m_win, m_age;
   bit       m_tick, m_src;
   bit [5:0] m_pb, m_pa;
   int       m_cd [6];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, m_cyc);
      end
   endtask

   task automatic model_step();
      bit [5:0] eb, ea, cand, clr_b, clr_a;
      bit use_auto, nt;
      int p, nphase;
      if (reset) begin
         m_cyc = 0; m_cnt = 0; m_sel = 0; m_lfsr = 1; m_rr = 0; m_phase = 0;
         m_win = 0; m_age = 0; m_tick = 0; m_src = 0; m_pb = '0; m_pa = '0;
         for (int i = 0; i < 6; i++) m_cd[i] = 0;
         return;
      end
      m_cyc++;
      for (int i = 0; i < 6; i++) begin
         eb[i] = m_pb[i] && (m_cd[i] == 0);
         ea[i] = m_pa[i] && (m_cd[i] == 0);
      end
      use_auto = (eb == 0);
`ifdef CARE_SCHED_AGING_EN
      if (m_age == 7 && ea != 0) use_auto = 1;
`endif
      cand = use_auto ? ea : eb;
      p = -1;
      nphase = 0;
      if (m_phase == 1) nphase = 2;
      else if (enable && m_cnt != TD - 1 && cand != 0) begin
         for (int k = 0; k < 6; k++)
            if (p < 0 && cand[(m_rr + k) % 6]) p = (m_rr + k) % 6;
         nphase = 1;
`ifdef CARE_SCHED_AGING_EN
         if (use_auto) m_age = 0;
         else if (ea != 0 && m_age < 7) m_age++;
`endif
      end
      if (m_tick)
         for (int i = 0; i < 6; i++) if (m_cd[i] > 0) m_cd[i]--;
      clr_b = '0; clr_a = '0;
      if (m_phase == 1) begin
         if (m_src) clr_a[m_win] = 1'b1; else clr_b[m_win] = 1'b1;
         m_cd[m_win] = CDN;
         m_rr = (m_win + 1) % 6;
      end
      if (p >= 0) begin m_win = p; m_src = use_auto; end
      if (enable) begin
         m_pb = (m_pb & ~clr_b) | req_btn;
         m_pa = (m_pa & ~clr_a) | req_auto;
      end else begin
         m_pb = '0; m_pa = '0;
      end
      nt = enable && (m_cnt == TD - 1);
      if (nt) m_sel = m_lfsr % 6;
      m_tick = nt;
      if (enable) m_cnt = (m_cnt == TD - 1) ? 0 : m_cnt + 1;
      m_lfsr = ((m_lfsr << 1) & 31) | (((m_lfsr >> 4) ^ (m_lfsr >> 2)) & 1);
      m_phase = nphase;
   endtask

   always @(posedge clk) if (started) model_step();

   logic [5:0] exp_pulse, exp_cool;
   always @(negedge clk) begin
      if (started) begin
         if (reset) chk("pulse_in_reset", act_pulse, 0);
         else begin
            exp_pulse = (m_phase == 1) ? (6'b000001 << m_win) : 6'b0;
            for (int i = 0; i < 6; i++) exp_cool[i] = (m_cd[i] != 0);
            chk("act_pulse", act_pulse, exp_pulse);
            if (exp_pulse != 0) chk("act_src", act_src, m_src);
            chk("decay_tick", decay_tick, m_tick);
            chk("decay_sel", decay_sel, m_sel);
            chk("cooling", cooling, exp_cool);
            chk("pulse_tick_overlap", (act_pulse != 0) && decay_tick, 0);
            chk("pulse_onehot", $countones(act_pulse) <= 1, 1);
            if (decay_tick) begin
               chk("sel_range", decay_sel < 6, 1);
               n_tick++;
            end
            if (act_pulse != 0) begin
               n_pulse++;
               if (act_src) n_auto++;
               $display("pulse cyc=%0d act=%b src=%0d", m_cyc, act_pulse, act_src);
            end
         end
      end
   end

   task automatic at_cyc(input int k);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (m_cyc != k && n < 300);
      if (m_cyc != k) chk("at_cyc_timeout", m_cyc, k);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk); #1;
      reset = 1; enable = 1; req_btn = '0; req_auto = '0; started = 1;
      repeat (2) @(negedge clk);
      #1 reset = 0;
      n_pulse = 0; n_auto = 0; n_tick = 0;
   endtask

   initial begin
      // Idle run: ticks at 8, 16, 24, no actions
      do_reset();
      chk("A_reset_pulse", act_pulse, 0);
      chk("A_reset_cool", cooling, 0);
      chk("A_reset_sel", decay_sel, 0);
      at_cyc(7);  chk("A_tick7", decay_tick, 0);
      at_cyc(8);  chk("A_tick8", decay_tick, 1);
      at_cyc(16); chk("A_tick16", decay_tick, 1);
      at_cyc(24); chk("A_tick24", decay_tick, 1);
      chk("A_tick_count", n_tick, 3);
      chk("A_no_pulse", n_pulse, 0);

      // Single button feed, cooldown, repeat request while cooling
      do_reset();
      at_cyc(2);  req_btn = 6'b000001;
      at_cyc(3);  req_btn = '0;  chk("B_no_early", act_pulse, 0);
      at_cyc(4);  chk("B_pulse", act_pulse, 6'b000001); chk("B_src", act_src, 0);
      at_cyc(5);  chk("B_cool_on", cooling[0], 1);
      at_cyc(10); req_btn = 6'b000001;
      at_cyc(11); req_btn = '0;
      at_cyc(16); chk("B_cool_16", cooling[0], 1); chk("B_held", act_pulse, 0);
      at_cyc(17); chk("B_cool_off", cooling[0], 0);
      at_cyc(18); chk("B_repeat", act_pulse, 6'b000001);
      at_cyc(20); chk("B_count", n_pulse, 2);

      // Mixed sources: btn 0, btn 2, auto 1; then rr check
      do_reset();
      at_cyc(1);  req_btn = 6'b000101; req_auto = 6'b000010;
      at_cyc(2);  req_btn = '0; req_auto = '0;
      at_cyc(3);  chk("C_p1", act_pulse, 6'h01); chk("C_s1", act_src, 0);
      at_cyc(4);  chk("C_gap1", act_pulse, 0);
      at_cyc(5);  chk("C_p2", act_pulse, 6'h04); chk("C_s2", act_src, 0);
      at_cyc(6);  chk("C_gap2", act_pulse, 0);
      at_cyc(7);  chk("C_p3", act_pulse, 6'h02); chk("C_s3", act_src, 1);
      at_cyc(9);  req_btn = 6'b101000;
      at_cyc(10); req_btn = '0;
      at_cyc(11); chk("C_rr_next", act_pulse, 6'h08);
      at_cyc(13); chk("C_rr_last", act_pulse, 6'h20);

      // Decision at counter=7 is deferred past the tick
      do_reset();
      at_cyc(6);  req_btn = 6'b001000;
      at_cyc(7);  req_btn = '0;
      at_cyc(8);  chk("D_tick", decay_tick, 1); chk("D_no_pulse", act_pulse, 0);
      at_cyc(9);  chk("D_pulse", act_pulse, 6'b001000);

      // Disabled: requests ignored, counter frozen at 3
      do_reset();
      at_cyc(3);  enable = 0; req_btn = 6'h3f; req_auto = 6'h3f;
      at_cyc(23); enable = 1; req_btn = '0; req_auto = '0;
      chk("E_no_pulse", n_pulse, 0); chk("E_no_tick", n_tick, 0);
      at_cyc(27); chk("E_tick27", decay_tick, 0);
      at_cyc(28); chk("E_tick28", decay_tick, 1);
      at_cyc(30); chk("E_pend_empty", n_pulse, 0);

      // Held requests on both sources: button keeps priority
      do_reset();
      at_cyc(1);  req_btn = 6'h3f; req_auto = 6'h20;
      at_cyc(9);  chk("F_pulse9", act_pulse, 6'h08);
      at_cyc(80); req_btn = '0; req_auto = '0;
      chk("F_many", n_pulse > 6, 1);
`ifndef CARE_SCHED_AGING_EN
      chk("F_no_auto", n_auto, 0);
`endif

      // Reset during a grant cycle suppresses the pulse
      do_reset();
      at_cyc(2);  req_btn = 6'b000001;
      at_cyc(3);  req_btn = '0;
      @(posedge clk); #1 reset = 1;
      @(negedge clk); #1 chk("G_abort", act_pulse, 0);
      @(negedge clk); #1 reset = 0;
      at_cyc(1);  chk("G_after", act_pulse, 0);
      at_cyc(10); chk("G_none", n_pulse, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
